// File: rtl/seven_seg_capture.sv
// Display monitor: snoops multiplexed seven-segment drive lines and rebuilds the
// per-digit BCD value, dp and validity after synchronising and stability filtering.
module seven_seg_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_seg,
    input  logic [3:0]  i_dig,
    output logic [15:0] o_digits,
    output logic [3:0]  o_dp,
    output logic [3:0]  o_valid,
    output logic        o_update,
    output logic        o_err
);

    localparam int unsigned SAMPLE_W   = 12;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [SAMPLE_W-1:0] SAMPLE_RST = {8'h00, 4'hF};
    localparam logic [CNT_W-1:0]    STABLE_CNT = CNT_W'(STABLE_CYCLES);

    logic [SAMPLE_W-1:0] sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [15:0]         digits_q, digits_d;
    logic [3:0]          dp_q, dp_d;
    logic [3:0]          valid_q, valid_d;
    logic                update_q, update_d;
    logic                err_q, err_d;

    logic [7:0] s_seg;
    logic [3:0] s_dig;
    logic       changed;
    logic       commit;
    logic [1:0] sel;
    logic [3:0] code;

    // Segment pattern (a..g) back to BCD; blank maps to A, anything else to F.
    function automatic logic [3:0] decode_seg(input logic [6:0] pat);
        case (pat)
            7'b1111110: decode_seg = 4'h0;
            7'b0110000: decode_seg = 4'h1;
            7'b1101101: decode_seg = 4'h2;
            7'b1111001: decode_seg = 4'h3;
            7'b0110011: decode_seg = 4'h4;
            7'b1011011: decode_seg = 4'h5;
            7'b1011111: decode_seg = 4'h6;
            7'b1110000: decode_seg = 4'h7;
            7'b1111111: decode_seg = 4'h8;
            7'b1111011: decode_seg = 4'h9;
            7'b0000000: decode_seg = 4'hA;
            default:    decode_seg = 4'hF;
        endcase
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q  <= SAMPLE_RST;
            sync2_q  <= SAMPLE_RST;
            prev_q   <= SAMPLE_RST;
            cnt_q    <= '0;
            digits_q <= '0;
            dp_q     <= '0;
            valid_q  <= '0;
            update_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sync1_q  <= {i_seg, i_dig};
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            dp_q     <= dp_d;
            valid_q  <= valid_d;
            update_q <= update_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        s_seg    = sync2_q[11:4];
        s_dig    = sync2_q[3:0];
        changed  = (sync2_q != prev_q);
        cnt_d    = cnt_q;
        digits_d = digits_q;
        dp_d     = dp_q;
        valid_d  = valid_q;
        update_d = 1'b0;
        err_d    = 1'b0;
        sel      = 2'd0;
        code     = decode_seg(s_seg[7:1]);

        if (changed) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q < STABLE_CNT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        for (int unsigned n = 0; n < NUM_DIGITS; n++) begin
            if (!s_dig[n]) begin
                sel = 2'(n);
            end
        end

        // A change always reloads the counter, so with STABLE_CYCLES=1 a change alone marks arrival.
        commit = (cnt_d == STABLE_CNT) && (changed || (cnt_q != STABLE_CNT)) && $onehot(~s_dig);

        if (commit) begin
            digits_d[{sel, 2'b00} +: 4] = code;
            dp_d[sel]                   = s_seg[0];
            valid_d[sel]                = 1'b1;
            update_d = (digits_q[{sel, 2'b00} +: 4] != code) || (dp_q[sel] != s_seg[0]) || !valid_q[sel];
            err_d    = (code == 4'hF);
        end
    end

    assign o_digits = digits_q;
    assign o_dp     = dp_q;
    assign o_valid  = valid_q;
    assign o_update = update_q;
    assign o_err    = err_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: directed display scenarios plus random scanning,
// compared every cycle against a run-length reference model of the display monitor.
module tb_seven_seg_capture;

    localparam int unsigned STABLE = 4;
    localparam logic [11:0] RST_SAMPLE = 12'h00F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  seg;
    logic [3:0]  dig;
    logic [15:0] o_digits;
    logic [3:0]  o_dp, o_valid;
    logic        o_update, o_err;

    int pass_cnt = 0;
    int total_cnt = 0;
    int upd_cnt = 0;
    int both_cnt = 0;

    // Segment drive patterns for 0..9 with dp off.
    logic [7:0] seg_tab [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

    // Reference model state
    logic [11:0] m_pipe, m_s;
    int          m_run;
    logic [15:0] m_digits;
    logic [3:0]  m_dp, m_valid;
    logic        m_upd, m_err;

    always #5 clk = ~clk;

    seven_seg_capture #(.STABLE_CYCLES(STABLE)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_seg    (seg),
        .i_dig    (dig),
        .o_digits (o_digits),
        .o_dp     (o_dp),
        .o_valid  (o_valid),
        .o_update (o_update),
        .o_err    (o_err)
    );

    function automatic logic [3:0] ref_decode(input logic [6:0] p);
        logic [3:0] r;
        r = (p == 7'd0) ? 4'hA : 4'hF;
        for (int i = 0; i < 10; i++) begin
            if (seg_tab[i][7:1] == p) r = 4'(i);
        end
        return r;
    endfunction

    function automatic int count_low(input logic [3:0] d);
        int c = 0;
        for (int i = 0; i < 4; i++) if (!d[i]) c++;
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pipe = RST_SAMPLE;
        m_s = RST_SAMPLE;
        m_run = 1;
        m_digits = '0; m_dp = '0; m_valid = '0; m_upd = 1'b0; m_err = 1'b0;
    endtask

    // One clock edge: commit when the filtered sample has just completed STABLE identical cycles.
    task automatic model_edge();
        logic [11:0] nxt;
        logic [3:0]  code;
        int          n;
        m_upd = 1'b0;
        m_err = 1'b0;
        if (m_run == STABLE && count_low(m_s[3:0]) == 1) begin
            n = 0;
            for (int i = 0; i < 4; i++) if (!m_s[i]) n = i;
            code = ref_decode(m_s[11:5]);
            m_upd = (m_digits[n*4 +: 4] != code) || (m_dp[n] != m_s[4]) || !m_valid[n];
            m_err = (code == 4'hF);
            m_digits[n*4 +: 4] = code;
            m_dp[n] = m_s[4];
            m_valid[n] = 1'b1;
        end
        nxt = m_pipe;
        m_pipe = {seg, dig};
        if (nxt == m_s) m_run++;
        else m_run = 1;
        m_s = nxt;
    endtask

    task automatic step(input logic [7:0] s, input logic [3:0] d);
        seg = s;
        dig = d;
        @(posedge clk);
        model_edge();
        #1;
        check("cycle", {6'd0, o_digits, o_dp, o_valid, o_update, o_err},
                       {6'd0, m_digits, m_dp, m_valid, m_upd, m_err});
        if (o_update) upd_cnt++;
        if (o_update && o_err) both_cnt++;
    endtask

    task automatic hold(input logic [7:0] s, input logic [3:0] d, input int n);
        for (int i = 0; i < n; i++) step(s, d);
    endtask

    initial begin
        logic [23:0] snap;
        logic [7:0]  rs;
        logic [3:0]  rd;

        rst_n = 1'b0;
        seg = 8'h00;
        dig = 4'hF;
        model_reset();
        #2;
        check("reset_outs", {11'd0, o_digits, o_dp, o_valid, o_update, o_err}, 32'd0);
        #5 rst_n = 1'b1;

        // Single digit 0 commit, then held without re-commit
        hold(8'hFC, 4'b1110, 12);
        check("d0_upd_once", upd_cnt, 1);
        check("d0_nibble", o_digits[3:0], 4'h0);
        check("d0_valid", o_valid, 4'b0001);

        // Scan 1,2,3,4 and repeat
        upd_cnt = 0;
        hold(8'h60, 4'b1110, 10); hold(8'hDA, 4'b1101, 10);
        hold(8'hF2, 4'b1011, 10); hold(8'h66, 4'b0111, 10);
        check("scan_digits", o_digits, 16'h4321);
        check("scan_valid", o_valid, 4'hF);
        check("scan_upd", upd_cnt, 4);
        upd_cnt = 0;
        hold(8'h60, 4'b1110, 10); hold(8'hDA, 4'b1101, 10);
        hold(8'hF2, 4'b1011, 10); hold(8'h66, 4'b0111, 10);
        check("rescan_upd", upd_cnt, 0);

        // Short glitch on digit 0 is filtered
        hold(8'hB6, 4'b1110, 10);
        check("d0_five", o_digits[3:0], 4'h5);
        upd_cnt = 0;
        hold(8'hFE, 4'b1110, 3);
        hold(8'hB6, 4'b1110, 10);
        check("glitch_nibble", o_digits[3:0], 4'h5);
        check("glitch_upd", upd_cnt, 0);

        // Unrecognised pattern on digit 2
        both_cnt = 0;
        hold(8'h92, 4'b1011, 8);
        check("bad_nibble", o_digits[11:8], 4'hF);
        check("bad_err_upd", both_cnt, 1);

        // Invalid selects never commit
        snap = {o_digits, o_dp, o_valid};
        upd_cnt = 0;
        hold(8'hFC, 4'b1100, 20);
        hold(8'hFC, 4'b1111, 20);
        check("inv_state", {8'd0, o_digits, o_dp, o_valid}, {8'd0, snap});
        check("inv_upd", upd_cnt, 0);
        hold(8'h01, 4'b0111, 8);
        check("blank_nibble", o_digits[15:12], 4'hA);
        check("blank_dp", o_dp[3], 1'b1);

        // Asynchronous reset mid-hold, then full-latency recommit
        #2 rst_n = 1'b0;
        #1;
        check("midrst_outs", {11'd0, o_digits, o_dp, o_valid, o_update, o_err}, 32'd0);
        model_reset();
        #2 rst_n = 1'b1;
        hold(8'h01, 4'b0111, 5);
        check("rst_valid_early", o_valid, 4'b0000);
        step(8'h01, 4'b0111);
        check("rst_valid_late", o_valid, 4'b1000);
        check("rst_upd", o_update, 1'b1);

        // Random scanning with occasional bad patterns and bad selects
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 9))
                0:       rs = 8'($urandom);
                1:       rs = {7'd0, 1'($urandom)};
                default: rs = seg_tab[$urandom_range(0, 9)] | {7'd0, 1'($urandom)};
            endcase
            if ($urandom_range(0, 7) == 0) rd = 4'($urandom);
            else rd = ~(4'b0001 << $urandom_range(0, 3));
            hold(rs, rd, int'($urandom_range(1, 8)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
